// File: rtl/wb_slave_mem_if.sv
// Wishbone B4 classic bus bundle between one master and the wb_slave_mem responder.
// Signal names follow the slave's point of view (_i driven by master, _o by slave).
interface wb_slave_mem_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) ();
  logic                    cyc_i;
  logic                    stb_i;
  logic                    we_i;
  logic [ADDR_WIDTH-1:0]   adr_i;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic [DATA_WIDTH/8-1:0] sel_i;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic                    ack_o;
  logic                    err_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    output dat_o, ack_o, err_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    input  dat_o, ack_o, err_o
  );
endinterface

// File: rtl/wb_slave_mem.sv
// Wishbone B4 classic single-access slave with a small word memory, byte-lane
// writes, optional wait states and error termination for undecoded addresses.
module wb_slave_mem #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int BASE_ADDR   = 0,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_slave_mem_if.slave   bus
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [2:0]              cnt_reg, cnt_next;

  logic                    we_reg;
  logic [ADDR_WIDTH-1:0]   adr_reg;
  logic [DATA_WIDTH-1:0]   dat_reg;
  logic [LANES-1:0]        sel_reg;

  logic                    ack_reg, err_reg;
  logic [DATA_WIDTH-1:0]   dat_o_reg;

  logic [DATA_WIDTH-1:0]   mem_reg [MEM_DEPTH] = '{default: '0};

  logic                    req;
  logic                    acc_we;
  logic [ADDR_WIDTH-1:0]   acc_adr;
  logic [DATA_WIDTH-1:0]   acc_dat;
  logic [LANES-1:0]        acc_sel;
  logic [ADDR_WIDTH:0]     idx;
  logic                    in_range;
  logic [IDX_W-1:0]        mem_idx;
  logic                    enter_resp;
  logic [LANES-1:0]        lane_we;

  assign req = bus.cyc_i & bus.stb_i;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_next = ST_RESP;
          end else begin
            cnt_next   = 3'(WAIT_STATES);
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Master withdrawing cyc_i abandons the transfer silently.
        if (!bus.cyc_i) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) begin
            state_next = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_reg == ST_IDLE && req) begin
      we_reg  <= bus.we_i;
      adr_reg <= bus.adr_i;
      dat_reg <= bus.dat_i;
      sel_reg <= bus.sel_i;
    end
  end

  // With no wait states the access happens on the accepting edge itself,
  // so the live bus fields are used until the latched copy is valid.
  always_comb begin
    acc_we  = we_reg;
    acc_adr = adr_reg;
    acc_dat = dat_reg;
    acc_sel = sel_reg;
    if (state_reg == ST_IDLE) begin
      acc_we  = bus.we_i;
      acc_adr = bus.adr_i;
      acc_dat = bus.dat_i;
      acc_sel = bus.sel_i;
    end
  end

  assign idx        = {1'b0, acc_adr} - (ADDR_WIDTH+1)'(BASE_ADDR);
  assign in_range   = (idx < (ADDR_WIDTH+1)'(MEM_DEPTH));
  assign mem_idx    = idx[IDX_W-1:0];
  assign enter_resp = (state_next == ST_RESP);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_we[gi] = enter_resp & acc_we & in_range & acc_sel[gi] & ~rst_i;
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < LANES; b++) begin
      if (lane_we[b]) begin
        mem_reg[mem_idx][8*b +: 8] <= acc_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      dat_o_reg <= '0;
    end else begin
      ack_reg <= enter_resp & in_range;
      err_reg <= enter_resp & ~in_range;
      if (enter_resp) begin
        if (!in_range) begin
          dat_o_reg <= '0;
        end else if (!acc_we) begin
          dat_o_reg <= mem_reg[mem_idx];
        end
      end
    end
  end

  assign bus.ack_o = ack_reg;
  assign bus.err_o = err_reg;
  assign bus.dat_o = dat_o_reg;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Randomised and directed bench for wb_slave_mem; three instances cover 0, 2 and 3
// wait states and are checked against a per-instance word-array model.
module tb_wb_slave_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [15:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  int          dsel = 0;

  logic        o_ack [3];
  logic        o_err [3];
  logic [31:0] o_dat [3];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_mem [3][16];
  int          ws_of [3] = '{0, 2, 3};

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int WS = (gi == 0) ? 0 : ((gi == 1) ? 2 : 3);
    wb_slave_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();
    assign bus.cyc_i = cyc & (dsel == gi);
    assign bus.stb_i = stb;
    assign bus.we_i  = we;
    assign bus.adr_i = adr;
    assign bus.dat_i = dat;
    assign bus.sel_i = sel;
    wb_slave_mem #(
      .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(16),
      .BASE_ADDR(0), .WAIT_STATES(WS)
    ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
    );
    assign o_ack[gi] = bus.ack_o;
    assign o_err[gi] = bus.err_o;
    assign o_dat[gi] = bus.dat_o;
  end

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Master-side single access; stb_i stays high through the ack cycle and the
  // following sample point, then responses are counted for a few more cycles.
  task automatic do_xfer(input int d, input logic w, input logic [15:0] a,
                         input logic [31:0] wd, input logic [3:0] s,
                         output logic [31:0] rd, output logic got_ack,
                         output logic got_err, output int lat, output int nresp);
    dsel = d; we = w; adr = a; dat = wd; sel = s; cyc = 1'b1; stb = 1'b1;
    lat = -1; nresp = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (o_ack[d] || o_err[d]) begin
        nresp++; lat = c; got_ack = o_ack[d]; got_err = o_err[d]; rd = o_dat[d];
        break;
      end
    end
    @(negedge clk);
    if (o_ack[d] || o_err[d]) nresp++;
    cyc = 1'b0; stb = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (o_ack[d] || o_err[d]) nresp++;
    end
    $display("xfer dut=%0d we=%0b adr=0x%04h wdat=0x%08h sel=%04b -> ack=%0b err=%0b rdat=0x%08h lat=%0d resp=%0d",
             d, w, a, wd, s, got_ack, got_err, rd, lat, nresp);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (o_ack[d] !== 1'b0 || o_err[d] !== 1'b0 || o_dat[d] !== 32'h0) begin
        n_bad++;
        $display("FAIL reset dut=%0d: ack=%b err=%b dat=0x%08h, required 0/0/0", d, o_ack[d], o_err[d], o_dat[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic ga, ge; int lat, nr;
    do_xfer(0, 1'b1, 16'd3, 32'hDEADBEEF, 4'b1111, rd, ga, ge, lat, nr);
    model_mem[0][3] = merge(model_mem[0][3], 32'hDEADBEEF, 4'b1111);
    n_cmp++;
    if (ga !== 1'b1 || ge !== 1'b0 || lat != 1 || nr != 1) begin
      n_bad++;
      $display("FAIL write_ack: ack=%b err=%b lat=%0d resp=%0d, required 1/0/1/1", ga, ge, lat, nr);
    end
    do_xfer(0, 1'b0, 16'd3, 32'h0, 4'b0000, rd, ga, ge, lat, nr);
    n_cmp++;
    if (ga !== 1'b1 || lat != 1 || nr != 1 || rd !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL read_back: ack=%b lat=%0d resp=%0d dat=0x%08h, required 1/1/1/0xdeadbeef", ga, lat, nr, rd);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic ga, ge; int lat, nr;
    do_xfer(0, 1'b1, 16'd3, 32'h00AA5500, 4'b0010, rd, ga, ge, lat, nr);
    model_mem[0][3] = merge(model_mem[0][3], 32'h00AA5500, 4'b0010);
    do_xfer(0, 1'b0, 16'd3, 32'h0, 4'b0000, rd, ga, ge, lat, nr);
    n_cmp++;
    if (rd !== 32'hDEAD55EF || ga !== 1'b1) begin
      n_bad++;
      $display("FAIL byte_lane: dat=0x%08h ack=%b, required 0xdead55ef/1", rd, ga);
    end
    do_xfer(0, 1'b1, 16'd3, 32'hFFFFFFFF, 4'b0000, rd, ga, ge, lat, nr);
    do_xfer(0, 1'b0, 16'd3, 32'h0, 4'b0000, rd, ga, ge, lat, nr);
    n_cmp++;
    if (rd !== 32'hDEAD55EF) begin
      n_bad++;
      $display("FAIL sel_zero_write: dat=0x%08h, required 0xdead55ef", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic ga, ge; int lat, nr;
    do_xfer(0, 1'b1, 16'd16, 32'h13579BDF, 4'b1111, rd, ga, ge, lat, nr);
    n_cmp++;
    if (ga !== 1'b0 || ge !== 1'b1 || nr != 1 || lat != 1) begin
      n_bad++;
      $display("FAIL oor_write: ack=%b err=%b resp=%0d lat=%0d, required 0/1/1/1", ga, ge, nr, lat);
    end
    do_xfer(0, 1'b0, 16'd16, 32'h0, 4'b1111, rd, ga, ge, lat, nr);
    n_cmp++;
    if (ga !== 1'b0 || ge !== 1'b1 || rd !== 32'h0 || nr != 1) begin
      n_bad++;
      $display("FAIL oor_read: ack=%b err=%b dat=0x%08h resp=%0d, required 0/1/0/1", ga, ge, rd, nr);
    end
    for (int a = 0; a < 16; a++) begin
      do_xfer(0, 1'b0, 16'(a), 32'h0, 4'b0000, rd, ga, ge, lat, nr);
      n_cmp++;
      if (rd !== model_mem[0][a] || ga !== 1'b1) begin
        n_bad++;
        $display("FAIL oor_unchanged adr=%0d: dat=0x%08h ack=%b, required 0x%08h/1", a, rd, ga, model_mem[0][a]);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic ga, ge; int lat, nr;
    do_xfer(1, 1'b0, 16'd0, 32'h0, 4'b1111, rd, ga, ge, lat, nr);
    n_cmp++;
    if (lat != 3 || nr != 1 || ga !== 1'b1 || rd !== model_mem[1][0]) begin
      n_bad++;
      $display("FAIL wait_latency: lat=%0d resp=%0d ack=%b dat=0x%08h, required 3/1/1/0x%08h", lat, nr, ga, rd, model_mem[1][0]);
    end
  endtask

  task automatic test_master_handshake();
    logic [31:0] rd, wd; logic ga, ge; int lat, nr, a;
    for (int i = 0; i < 16; i++) begin
      a = (5 + i) % 16;
      wd = $urandom;
      do_xfer(0, 1'b1, 16'(a), wd, 4'b1111, rd, ga, ge, lat, nr);
      model_mem[0][a] = wd;
      n_cmp++;
      if (ga !== 1'b1 || nr != 1) begin
        n_bad++;
        $display("FAIL handshake_write adr=%0d: ack=%b resp=%0d, required 1/1", a, ga, nr);
      end
      do_xfer(0, 1'b0, 16'(a), 32'h0, 4'b1111, rd, ga, ge, lat, nr);
      n_cmp++;
      if (rd !== wd || nr != 1) begin
        n_bad++;
        $display("FAIL handshake_read adr=%0d: dat=0x%08h resp=%0d, required 0x%08h/1", a, rd, nr, wd);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic ga, ge; int lat, nr, seen;
    dsel = 2; we = 1'b1; adr = 16'd9; dat = 32'hA5A5A5A5; sel = 4'b1111; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_ack[2] || o_err[2]) seen++;
    end
    $display("abort dut=2 adr=0x0009 responses=%0d", seen);
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL abort_no_resp: responses=%0d, required 0", seen);
    end
    do_xfer(2, 1'b0, 16'd9, 32'h0, 4'b1111, rd, ga, ge, lat, nr);
    n_cmp++;
    if (rd !== model_mem[2][9] || lat != 4) begin
      n_bad++;
      $display("FAIL abort_mem: dat=0x%08h lat=%0d, required 0x%08h/4", rd, lat, model_mem[2][9]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic ga, ge; int lat, nr, seen;
    do_xfer(2, 1'b1, 16'd7, 32'h12345678, 4'b1111, rd, ga, ge, lat, nr);
    model_mem[2][7] = 32'h12345678;
    do_xfer(2, 1'b0, 16'd7, 32'h0, 4'b1111, rd, ga, ge, lat, nr);
    dsel = 2; we = 1'b1; adr = 16'd7; dat = 32'hCAFEF00D; sel = 4'b1111; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    $display("reset_mid dut=2 ack=%0b err=%0b dat=0x%08h", o_ack[2], o_err[2], o_dat[2]);
    n_cmp++;
    if (o_ack[2] !== 1'b0 || o_err[2] !== 1'b0 || o_dat[2] !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mid_out: ack=%b err=%b dat=0x%08h, required 0/0/0", o_ack[2], o_err[2], o_dat[2]);
    end
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_ack[2] || o_err[2]) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL reset_mid_resp: responses=%0d, required 0", seen);
    end
    do_xfer(2, 1'b0, 16'd7, 32'h0, 4'b1111, rd, ga, ge, lat, nr);
    n_cmp++;
    if (rd !== 32'h12345678 || lat != 4 || nr != 1) begin
      n_bad++;
      $display("FAIL reset_mid_drop: dat=0x%08h lat=%0d resp=%0d, required 0x12345678/4/1", rd, lat, nr);
    end
  endtask

  task automatic test_random(input int d, input int n);
    logic [31:0] rd, wd, exp_rd; logic ga, ge, w, exp_ok; logic [3:0] s; logic [15:0] a; int lat, nr;
    for (int i = 0; i < n; i++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 16'($urandom_range(0, 19));
      wd = $urandom;
      s  = 4'($urandom_range(0, 15));
      exp_ok = (a < 16);
      exp_rd = exp_ok ? model_mem[d][a[3:0]] : 32'h0;
      do_xfer(d, w, a, wd, s, rd, ga, ge, lat, nr);
      n_cmp++;
      if (ga !== exp_ok || ge !== !exp_ok || nr != 1 || lat != ws_of[d] + 1) begin
        n_bad++;
        $display("FAIL random_resp dut=%0d adr=%0d: ack=%b err=%b resp=%0d lat=%0d, required %b/%b/1/%0d",
                 d, a, ga, ge, nr, lat, exp_ok, !exp_ok, ws_of[d] + 1);
      end
      if (!w || !exp_ok) begin
        n_cmp++;
        if (rd !== exp_rd) begin
          n_bad++;
          $display("FAIL random_data dut=%0d adr=%0d: dat=0x%08h, required 0x%08h", d, a, rd, exp_rd);
        end
      end
      if (w && exp_ok) model_mem[d][a[3:0]] = merge(model_mem[d][a[3:0]], wd, s);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 16; a++) model_mem[d][a] = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_wait_states();
    test_master_handshake();
    test_abort();
    test_reset_mid();
    test_random(0, 25);
    test_random(1, 25);
    test_random(2, 25);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_slave_mem.md
Name: wb_slave_mem

Overview:
Wishbone B4 classic (non-pipelined) slave holding a small word-addressed memory. It is the responder side for the sequential-access master: it accepts SINGLE WRITE and SINGLE READ cycles and answers each with exactly one ack_o or err_o pulse. It supports byte-lane writes and a configurable number of wait states. It sits on the shared bus opposite one master, with no interconnect arbitration.

Parameters:
ADDR_WIDTH, 16, width of adr_i (word address)
DATA_WIDTH, 32, data width; must be a multiple of 8
MEM_DEPTH, 16, number of words stored
BASE_ADDR, 0, first decoded word address; valid range is BASE_ADDR..BASE_ADDR+MEM_DEPTH-1
WAIT_STATES, 0, extra cycles inserted before the response; legal range 0..7

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-high
cyc_i  in  1  bus cycle valid
stb_i  in  1  strobe / transfer request
we_i  in  1  1 = write, 0 = read
adr_i  in  ADDR_WIDTH  word address
dat_i  in  DATA_WIDTH  write data
sel_i  in  DATA_WIDTH/8  byte-lane enables; bit n covers dat bits [8n+7:8n]
dat_o  out  DATA_WIDTH  read data
ack_o  out  1  normal termination, one-cycle pulse
err_o  out  1  error termination, one-cycle pulse

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values: state IDLE, ack_o=0, err_o=0, dat_o=0, wait counter=0.
- Memory contents are not cleared by reset. They are zero at time 0.
- States:
  - IDLE: request = cyc_i & stb_i. On request, latch we_i, adr_i, dat_i and sel_i.
    - WAIT_STATES=0: go to RESP.
    - Otherwise: load counter with WAIT_STATES and go to WAIT.
  - WAIT: decrement counter each cycle. When counter reaches 1, go to RESP.
    - If cyc_i=0 in any WAIT cycle: abort, return to IDLE, no response, no write.
  - RESP: one cycle with ack_o or err_o high. Always returns to IDLE on the next edge, regardless of stb_i.
- Latency: response is visible WAIT_STATES+1 cycles after the edge that accepted the request.
- Re-ack prevention: a request is only accepted in IDLE. In IDLE, ack_o and err_o are low. The master's stb_i is still high during the cycle ack_o is high, and this must not start a second transfer. Each accepted request produces exactly one response pulse.
- Decode: idx = latched adr - BASE_ADDR, computed in ADDR_WIDTH+1 bits.
  - In range: 0 <= idx < MEM_DEPTH.
  - Out of range: err_o=1 instead of ack_o, no memory write, dat_o=0.
- Write: memory is updated on the edge entering RESP, and only lanes with sel bit set are written. sel=0 still acks and writes nothing.
- Read: dat_o is loaded on the edge entering RESP with the full word (sel ignored). Between responses dat_o holds its last value.
- ack_o and err_o are never high together. Both are registered outputs with no combinational path from inputs.
- stb_i without cyc_i is ignored.
- Reset mid-operation: from WAIT or RESP, return to IDLE next edge with outputs cleared. A pending write is dropped.

Test Plan:
- Write then read: write 0xDEADBEEF to adr 3 with sel=4'b1111, then read adr 3. Each cycle gets ack_o one cycle after acceptance; the read returns dat_o=0xDEADBEEF.
- Byte lanes: after the above, write 0x00AA5500 to adr 3 with sel=4'b0010, then read adr 3 -> 0xDEAD55EF.
- Out of range: with MEM_DEPTH=16 and BASE_ADDR=0, write adr 16 -> single err_o pulse, ack_o stays 0. Read adr 16 -> err_o, dat_o=0. Memory words 0..15 are unchanged.
- Wait states: with WAIT_STATES=2, read adr 0 -> ack_o exactly 3 cycles after acceptance, for exactly 1 cycle.
- Master-style handshake: hold stb_i high until the cycle after ack_o is seen, then run 16 write/read pairs over adr 0..15 wrapping to 0. Exactly one ack per transfer, and every readback matches the written data.
- Abort and reset: with WAIT_STATES=3, drop cyc_i during WAIT on a write -> no ack, memory unchanged. Assert rst_i during WAIT -> next cycle IDLE with ack_o=err_o=dat_o=0.
